// File: rtl/ccip_mmio_host_initiator.sv
// ccip_mmio_host_initiator: CCI-P host MMIO initiator issuing C0 Rx requests and collecting C2 Tx read responses.
// Defining CCIP_MMIO_HOST_LAT_STATS_EN adds stat_rd_count / stat_rd_max_lat read statistics.
module ccip_mmio_host_initiator #(
    parameter int TIMEOUT   = 512,
    parameter int TID_WIDTH = 9
) (
    input  logic                 pClk,
    input  logic                 pck_cp2af_softReset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [15:0]          cmd_addr,
    input  logic [1:0]           cmd_len,
    input  logic [511:0]         cmd_wdata,
    output logic [27:0]          rx_c0_hdr,
    output logic [511:0]         rx_c0_data,
    output logic                 rx_c0_mmioRdValid,
    output logic                 rx_c0_mmioWrValid,
    input  logic [TID_WIDTH-1:0] tx_c2_tid,
    input  logic                 tx_c2_mmioRdValid,
    input  logic [63:0]          tx_c2_data,
    output logic                 rsp_valid,
    output logic [63:0]          rsp_data,
    output logic                 rsp_timeout,
    output logic [TID_WIDTH-1:0] rsp_tid,
    output logic                 err_illegal_cmd,
    output logic                 err_unexp_rsp
`ifdef CCIP_MMIO_HOST_LAT_STATS_EN
    ,
    output logic [31:0]          stat_rd_count,
    output logic [15:0]          stat_rd_max_lat
`endif
);
    localparam int TW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t               state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic [27:0]          hdr_q, hdr_d;
    logic [511:0]         data_q, data_d;
    logic                 rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d;
    logic [TID_WIDTH-1:0] tid_ctr_q, tid_ctr_d, tid_lat_q, tid_lat_d, rsp_tid_q, rsp_tid_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [63:0]          rsp_data_q, rsp_data_d;
    logic                 err_ill_q, err_ill_d, err_unexp_q, err_unexp_d;
    logic                 accept, illegal, tid_hit, timed_out;
`ifdef CCIP_MMIO_HOST_LAT_STATS_EN
    logic [31:0]          stat_cnt_q, stat_cnt_d;
    logic [15:0]          stat_max_q, stat_max_d;
`endif

    always_comb begin
        accept    = cmd_valid && cmd_ready_q && state_q == IDLE;
        illegal   = cmd_len == 2'b11 || (cmd_len == 2'b01 && cmd_addr[0]) ||
                    (cmd_len == 2'b10 && cmd_addr[3:0] != 4'h0) || (!cmd_write && cmd_len == 2'b10);
        // timer_q holds N, the cycle count since the issue cycle
        tid_hit   = tx_c2_mmioRdValid && state_q == WAIT_RD && tx_c2_tid == tid_lat_q;
        timed_out = state_q == WAIT_RD && timer_q == TW'(TIMEOUT) && !tid_hit;
        state_d       = state_q;
        hdr_d         = hdr_q;
        data_d        = data_q;
        rd_stb_d      = 1'b0;
        wr_stb_d      = 1'b0;
        tid_ctr_d     = tid_ctr_q;
        tid_lat_d     = tid_lat_q;
        timer_d       = timer_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_tid_d     = rsp_tid_q;
        err_ill_d     = accept && illegal;
        err_unexp_d   = tx_c2_mmioRdValid && !tid_hit;
        case (state_q)
            IDLE: begin
                if (accept && !illegal) begin
                    state_d  = ISSUE;
                    hdr_d    = {cmd_addr, cmd_len, 1'b0, tid_ctr_q};
                    data_d   = !cmd_write ? '0 : cmd_len == 2'b10 ? cmd_wdata : {448'b0, cmd_wdata[63:0]};
                    wr_stb_d = cmd_write;
                    rd_stb_d = !cmd_write;
                end
            end
            ISSUE: begin
                tid_ctr_d = tid_ctr_q + 1'b1;
                state_d   = rd_stb_q ? WAIT_RD : IDLE;
                tid_lat_d = rd_stb_q ? tid_ctr_q : tid_lat_q;
                timer_d   = TW'(1);
            end
            WAIT_RD: begin
                timer_d = timer_q + 1'b1;
                if (tid_hit || timed_out) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = !tid_hit;
                    rsp_data_d    = tid_hit ? tx_c2_data : 64'h0;
                    rsp_tid_d     = tid_lat_q;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = state_d == IDLE;
`ifdef CCIP_MMIO_HOST_LAT_STATS_EN
        stat_cnt_d = stat_cnt_q;
        stat_max_d = stat_max_q;
        if (tid_hit) begin
            stat_cnt_d = &stat_cnt_q ? stat_cnt_q : stat_cnt_q + 1'b1;
            stat_max_d = 16'(timer_q) > stat_max_q ? 16'(timer_q) : stat_max_q;
        end
`endif
    end

    // cmd_ready stays low while reset is held and rises on the first clock after release
    always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
        if (pck_cp2af_softReset) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            hdr_q         <= '0;
            data_q        <= '0;
            rd_stb_q      <= 1'b0;
            wr_stb_q      <= 1'b0;
            tid_ctr_q     <= '0;
            tid_lat_q     <= '0;
            timer_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= '0;
            rsp_tid_q     <= '0;
            err_ill_q     <= 1'b0;
            err_unexp_q   <= 1'b0;
`ifdef CCIP_MMIO_HOST_LAT_STATS_EN
            stat_cnt_q    <= '0;
            stat_max_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            hdr_q         <= hdr_d;
            data_q        <= data_d;
            rd_stb_q      <= rd_stb_d;
            wr_stb_q      <= wr_stb_d;
            tid_ctr_q     <= tid_ctr_d;
            tid_lat_q     <= tid_lat_d;
            timer_q       <= timer_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_data_q    <= rsp_data_d;
            rsp_tid_q     <= rsp_tid_d;
            err_ill_q     <= err_ill_d;
            err_unexp_q   <= err_unexp_d;
`ifdef CCIP_MMIO_HOST_LAT_STATS_EN
            stat_cnt_q    <= stat_cnt_d;
            stat_max_q    <= stat_max_d;
`endif
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign rx_c0_hdr         = hdr_q;
    assign rx_c0_data        = data_q;
    assign rx_c0_mmioRdValid = rd_stb_q;
    assign rx_c0_mmioWrValid = wr_stb_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rsp_data_q;
    assign rsp_timeout       = rsp_timeout_q;
    assign rsp_tid           = rsp_tid_q;
    assign err_illegal_cmd   = err_ill_q;
    assign err_unexp_rsp     = err_unexp_q;
`ifdef CCIP_MMIO_HOST_LAT_STATS_EN
    assign stat_rd_count     = stat_cnt_q;
    assign stat_rd_max_lat   = stat_max_q;
`endif
endmodule
